mc_main_fsm: RTL
================

# mc_main_fsm

Main control state machine for the multicycle microprocessor. It sequences the shared ALU, the memory port and the enable-gated `flipflop` registers (PC, IR, data and ALU-result registers) through the fetch, decode, execute, memory and writeback steps. It decodes `op`/`funct` from the instruction register and drives every select and write-enable of the multicycle datapath. It sits between the IR and the datapath; condition-check gating of `reg_w`, `mem_w` and `branch` is applied downstream.

## Interface
- `MEM_LAT`, default 0: extra wait cycles per memory access (0–15).
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high.
- `op`  in  2  instruction class: 00 data-processing, 01 memory, 10 branch, 11 undefined.
- `funct`  in  6  `funct[5]` is I (immediate); `funct[0]` is L (load) for memory instructions.
- `ir_write`  out  1  IR load enable.
- `next_pc`  out  1  PC load enable.
- `adr_src`  out  1  memory address: 0 = PC, 1 = result.
- `alu_src_a`  out  1  0 = register A, 1 = PC.
- `alu_src_b`  out  2  00 = register B, 01 = extended immediate, 10 = constant 4.
- `alu_op`  out  1  0 = add, 1 = decode by funct.
- `result_src`  out  2  00 = ALU-out register, 01 = data register, 10 = ALU direct.
- `reg_w`  out  1  register-file write.
- `mem_w`  out  1  memory write.
- `branch`  out  1  branch PC load.
- `state`  out  4  current state code, for debug.
- `fault`  out  1  undefined-instruction flag (see Configuration).

## Operation
- Moore machine: all outputs decode from the registered state plus the wait-counter-done flag. Any output not listed for a state is 0.
- States and outputs:
  - FETCH: `alu_src_a`=1, `alu_src_b`=10, `result_src`=10. `ir_write` and `next_pc` are asserted only on the last wait cycle.
  - DECODE: `alu_src_a`=1, `alu_src_b`=10, `result_src`=10.
  - MEMADR: `alu_src_b`=01.
  - MEMRD: `adr_src`=1.
  - MEMWB: `result_src`=01, `reg_w`=1.
  - MEMWR: `adr_src`=1. `mem_w` is asserted only on the last wait cycle.
  - EXECR: `alu_op`=1.
  - EXECI: `alu_op`=1, `alu_src_b`=01.
  - ALUWB: `reg_w`=1.
  - BRANCH: `alu_src_b`=01, `result_src`=10, `branch`=1.
- Transitions:
  - FETCH → DECODE once the wait is done.
  - DECODE: `op`=01 → MEMADR; `op`=00 with `funct[5]`=1 → EXECI, with `funct[5]`=0 → EXECR; `op`=10 → BRANCH; `op`=11 → see Configuration.
  - MEMADR → MEMRD if `funct[0]`=1, otherwise MEMWR.
  - MEMRD → MEMWB once the wait is done.
  - MEMWR → FETCH once the wait is done.
  - EXECR and EXECI → ALUWB.
  - MEMWB, ALUWB and BRANCH → FETCH.
- Wait counter: 4 bits. Loads 0 on entry to FETCH, MEMRD or MEMWR and increments each cycle in those states; done when count == `MEM_LAT`. With `MEM_LAT`=0 each of these states lasts exactly 1 cycle.
- `op`/`funct` are sampled only in DECODE and MEMADR; they are don't-care in all other states.

## Timing
- Reset: a rising edge with `reset`=1 forces state=FETCH, counter=0, `fault`=0. Reset takes priority over every transition, including mid-wait.
- All outputs are valid combinationally in the cycle after each state update; no output is registered separately.
- Cycles per instruction = base + `MEM_LAT` × accesses:
  - LDR: 5 + 2L
  - STR: 4 + 2L
  - data-processing: 4 + L
  - B: 3 + L
- `ir_write` and `next_pc` pulse exactly once per instruction, together. `reg_w` pulses at most once per instruction.

## Configuration
- `MC_FSM_FAULT_EN` defined:
  - `op`=11 in DECODE → FAULT state (code 4'hF), all enables 0, `fault`=1.
  - FAULT holds until reset.
- `MC_FSM_FAULT_EN` undefined:
  - `op`=11 in DECODE → FETCH; the instruction executes as a 2-cycle no-op.
  - FAULT state is absent; `fault` is tied to 0.

## Structure
- Package `mc_pkg`: state code localparams (FETCH=0 … BRANCH=9, FAULT=15), `op` class codes, `alu_src_b` and `result_src` select encodings.
- One sub-module, `mc_wait_cnt`: counter with load, increment and done, parameterised by `MEM_LAT`.
- The state register and output decode stay in `mc_main_fsm`.

## Test plan
- Reset then LDR (`op`=01, `funct`=000001), `MEM_LAT`=0 → states 0,1,2,3,4,0; `reg_w` high only in cycle 5; `result_src`=01 in that cycle.
- STR (`funct`=000000), `MEM_LAT`=2 → FETCH 3 cycles, MEMWR 3 cycles; `mem_w` high only in the third MEMWR cycle; 8 cycles total.
- DP immediate (`op`=00, `funct`=100000) → DECODE, EXECI (`alu_op`=1, `alu_src_b`=01), ALUWB (`reg_w`=1), FETCH. Same stimulus with `funct[5]`=0 → EXECR with `alu_src_b`=00.
- B (`op`=10) → BRANCH with `branch`=1, `result_src`=10; returns to FETCH after 3 cycles.
- `reset` asserted during the second MEMRD wait cycle (`MEM_LAT`=3) → next state FETCH, counter 0, no `reg_w` pulse.
- `op`=11: with `MC_FSM_FAULT_EN` → `fault`=1 and state 4'hF held for 10 cycles until reset; without it → state back to FETCH, `fault`=0.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle main control FSM.
// The FAULT state exists only when MC_FSM_FAULT_EN is defined.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
`ifdef MC_FSM_FAULT_EN
    ,
    S_FAULT  = 4'hF
`endif
  } state_t;

  localparam logic [1:0] OP_DP    = 2'b00;
  localparam logic [1:0] OP_MEM   = 2'b01;
  localparam logic [1:0] OP_BR    = 2'b10;
  localparam logic [1:0] OP_UNDEF = 2'b11;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // States that own the memory port and therefore run the wait counter.
  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mc_wait_cnt.sv
// Memory wait counter: cleared on load, counts up to MEM_LAT and holds there.
module mc_wait_cnt #(
  parameter int unsigned MEM_LAT = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic inc,
  output logic done
);
  import mc_pkg::*;

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  logic [3:0] count;

  assign done = (count == LAT);

  always_ff @(posedge clk) begin
    if (reset || load)
      count <= '0;
    else if (inc && !done)
      count <= count + 4'd1;
  end

endmodule

// File: rtl/mc_main_fsm.sv
// Main control FSM of the multicycle processor (Moore, state + wait-done decode).
// Optional undefined-instruction trap enabled by defining MC_FSM_FAULT_EN.
module mc_main_fsm #(
  parameter int unsigned MEM_LAT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  output logic       ir_write,
  output logic       next_pc,
  output logic       adr_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       alu_op,
  output logic [1:0] result_src,
  output logic       reg_w,
  output logic       mem_w,
  output logic       branch,
  output logic [3:0] state,
  output logic       fault
);
  import mc_pkg::*;

  state_t cur_state, nxt_state;
  logic   wait_done;
  logic   unused_funct;

  assign unused_funct = ^funct[4:1];

  // Any state change reloads the counter, which covers every entry to a wait state.
  mc_wait_cnt #(.MEM_LAT(MEM_LAT)) u_wait_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (nxt_state != cur_state),
    .inc   (is_wait_state(cur_state)),
    .done  (wait_done)
  );

  always_ff @(posedge clk) begin
    if (reset)
      cur_state <= S_FETCH;
    else
      cur_state <= nxt_state;
  end

  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      S_FETCH:  if (wait_done) nxt_state = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_MEM:  nxt_state = S_MEMADR;
          OP_DP:   nxt_state = funct[5] ? S_EXECI : S_EXECR;
          OP_BR:   nxt_state = S_BRANCH;
`ifdef MC_FSM_FAULT_EN
          default: nxt_state = S_FAULT;
`else
          default: nxt_state = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: nxt_state = funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (wait_done) nxt_state = S_MEMWB;
      S_MEMWR:  if (wait_done) nxt_state = S_FETCH;
      S_EXECR,
      S_EXECI:  nxt_state = S_ALUWB;
      S_MEMWB,
      S_ALUWB,
      S_BRANCH: nxt_state = S_FETCH;
`ifdef MC_FSM_FAULT_EN
      S_FAULT:  nxt_state = S_FAULT;
`endif
      default:  nxt_state = S_FETCH;
    endcase
  end

  always_comb begin
    ir_write   = 1'b0;
    next_pc    = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    alu_op     = 1'b0;
    result_src = RES_ALUOUT;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    branch     = 1'b0;
    case (cur_state)
      S_FETCH: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        ir_write   = wait_done;
        next_pc    = wait_done;
      end
      S_DECODE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
      end
      S_MEMADR: alu_src_b = SRCB_IMM;
      S_MEMRD:  adr_src = 1'b1;
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_w      = 1'b1;
      end
      S_MEMWR: begin
        adr_src = 1'b1;
        mem_w   = wait_done;
      end
      S_EXECR:  alu_op = 1'b1;
      S_EXECI: begin
        alu_op    = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_ALUWB:  reg_w = 1'b1;
      S_BRANCH: begin
        alu_src_b  = SRCB_IMM;
        result_src = RES_ALU;
        branch     = 1'b1;
      end
      default: ;
    endcase
  end

  assign state = cur_state;

`ifdef MC_FSM_FAULT_EN
  assign fault = (cur_state == S_FAULT);
`else
  assign fault = 1'b0;
`endif

endmodule
